// File: rtl/str_builder.sv
// Line-editing string buffer with cursor; commit streams the string plus a 0x00 terminator.
// Define STR_BUILDER_INSERT_EN for insert mode; the default build overwrites at the cursor.
module str_builder #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          i_sclr,
    input  logic [7:0]    i_ascii,
    input  logic          i_ascii_en,
    input  logic          i_right_en,
    input  logic          i_left_en,
    input  logic          i_bs_en,
    input  logic          i_down_en,
    output logic [7:0]    o_tx_data,
    output logic          o_tx_valid,
    input  logic          i_tx_ready,
    output logic          o_busy,
    output logic          o_full,
    output logic [AW:0]   o_len,
    output logic [AW:0]   o_cursor,
    output logic [7:0]    o_cur_char
);

    localparam int unsigned DEPTH   = 2 ** AW;
    localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE     = (AW+1)'(1);

    typedef enum logic {
        ST_EDIT,
        ST_SEND
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [7:0]    r_buf [DEPTH];
    logic [AW:0]   r_len;
    logic [AW:0]   r_cur;
    logic [AW:0]   r_idx;
    logic [7:0]    r_tx_data;
    logic          r_tx_valid;

    logic          w_edit;
    logic          w_room;
    logic          w_grow;
    logic          w_do_ascii;
    logic          w_do_bs;
    logic          w_do_right;
    logic          w_do_left;
    logic          w_do_down;
    logic          w_xfer;
    logic          w_term;
    logic [AW:0]   w_idx_nxt;
    logic [AW-1:0] w_cur_m1;

`ifdef STR_BUILDER_INSERT_EN
    assign w_room = (r_len != LEN_MAX);
    assign w_grow = 1'b1;
`else
    assign w_room = (r_cur != LEN_MAX);
    assign w_grow = (r_cur == r_len);
`endif

    // Strict priority ascii > bs > right > left > down; a present higher strobe masks lower ones.
    always_comb begin
        w_edit     = (r_state == ST_EDIT);
        w_do_ascii = w_edit & i_ascii_en & w_room;
        w_do_bs    = w_edit & ~i_ascii_en & i_bs_en & (r_cur != '0);
        w_do_right = w_edit & ~i_ascii_en & ~i_bs_en & i_right_en & (r_cur < r_len);
        w_do_left  = w_edit & ~i_ascii_en & ~i_bs_en & ~i_right_en & i_left_en & (r_cur != '0);
        w_do_down  = w_edit & ~i_ascii_en & ~i_bs_en & ~i_right_en & ~i_left_en & i_down_en;
        w_xfer     = (r_state == ST_SEND) & i_tx_ready;
        w_term     = w_xfer & (r_idx == r_len);
        w_idx_nxt  = r_idx + ONE;
        w_cur_m1   = r_cur[AW-1:0] - AW'(1);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EDIT: if (w_do_down) w_state_nxt = ST_SEND;
            ST_SEND: if (w_term)    w_state_nxt = ST_EDIT;
            default: w_state_nxt = ST_EDIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_sclr) r_state <= ST_EDIT;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (i_sclr) begin
            r_len      <= '0;
            r_cur      <= '0;
            r_idx      <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
        end else begin
            if (w_do_ascii) begin
                r_cur <= r_cur + ONE;
                if (w_grow) r_len <= r_len + ONE;
            end else if (w_do_bs) begin
                r_cur <= r_cur - ONE;
                r_len <= r_len - ONE;
            end else if (w_do_right) begin
                r_cur <= r_cur + ONE;
            end else if (w_do_left) begin
                r_cur <= r_cur - ONE;
            end else if (w_do_down) begin
                r_idx      <= '0;
                r_tx_valid <= 1'b1;
                r_tx_data  <= (r_len == '0) ? 8'h00 : r_buf[0];
            end

            // Output byte is preloaded from the next index so data/valid stay registered.
            if (w_term) begin
                r_tx_valid <= 1'b0;
                r_tx_data  <= '0;
                r_len      <= '0;
                r_cur      <= '0;
                r_idx      <= '0;
            end else if (w_xfer) begin
                r_idx     <= w_idx_nxt;
                r_tx_data <= (w_idx_nxt == r_len) ? 8'h00 : r_buf[w_idx_nxt[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_ascii) begin
`ifdef STR_BUILDER_INSERT_EN
            for (int unsigned i = 1; i < DEPTH; i++) begin
                if ((AW+1)'(i) > r_cur && (AW+1)'(i) <= r_len) r_buf[i] <= r_buf[i-1];
            end
`endif
            r_buf[r_cur[AW-1:0]] <= i_ascii;
        end else if (w_do_bs) begin
            for (int unsigned i = 0; i < DEPTH - 1; i++) begin
                if ((AW+1)'(i + 1) >= r_cur && (AW+1)'(i + 1) < r_len) r_buf[i] <= r_buf[i+1];
            end
        end
    end

    assign o_tx_data  = r_tx_data;
    assign o_tx_valid = r_tx_valid;
    assign o_busy     = (r_state == ST_SEND);
    assign o_full     = (r_len == LEN_MAX);
    assign o_len      = r_len;
    assign o_cursor   = r_cur;
    assign o_cur_char = (r_cur == '0) ? 8'h00 : r_buf[w_cur_m1];

endmodule

// File: tb/tb_str_builder.sv
// Directed self-checking bench for str_builder (AW = 4); expectations follow the build mode macro.
module tb_str_builder;

    localparam int AW = 4;

    localparam logic [4:0] EV_ASCII = 5'b00001;
    localparam logic [4:0] EV_BS    = 5'b00010;
    localparam logic [4:0] EV_RIGHT = 5'b00100;
    localparam logic [4:0] EV_LEFT  = 5'b01000;
    localparam logic [4:0] EV_DOWN  = 5'b10000;

    logic          clk = 1'b0;
    logic          i_sclr = 1'b0;
    logic [7:0]    i_ascii = '0;
    logic          i_ascii_en = 1'b0;
    logic          i_right_en = 1'b0;
    logic          i_left_en = 1'b0;
    logic          i_bs_en = 1'b0;
    logic          i_down_en = 1'b0;
    logic [7:0]    o_tx_data;
    logic          o_tx_valid;
    logic          i_tx_ready = 1'b1;
    logic          o_busy;
    logic          o_full;
    logic [AW:0]   o_len;
    logic [AW:0]   o_cursor;
    logic [7:0]    o_cur_char;

    int n_checks = 0;
    int n_errors = 0;

    str_builder #(.AW(AW)) dut (
        .clk        (clk),
        .i_sclr     (i_sclr),
        .i_ascii    (i_ascii),
        .i_ascii_en (i_ascii_en),
        .i_right_en (i_right_en),
        .i_left_en  (i_left_en),
        .i_bs_en    (i_bs_en),
        .i_down_en  (i_down_en),
        .o_tx_data  (o_tx_data),
        .o_tx_valid (o_tx_valid),
        .i_tx_ready (i_tx_ready),
        .o_busy     (o_busy),
        .o_full     (o_full),
        .o_len      (o_len),
        .o_cursor   (o_cursor),
        .o_cur_char (o_cur_char)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_ev(input logic [4:0] ev, input logic [7:0] c);
        {i_down_en, i_left_en, i_right_en, i_bs_en, i_ascii_en} = ev;
        i_ascii = c;
        @(posedge clk);
        #1;
        {i_down_en, i_left_en, i_right_en, i_bs_en, i_ascii_en} = '0;
    endtask

    task automatic check_edit(input string tag, input int len, input int cur, input logic [7:0] ch);
        check({tag, ".len"},  32'(o_len),    32'(len));
        check({tag, ".cur"},  32'(o_cursor), 32'(cur));
        check({tag, ".char"}, 32'(o_cur_char), 32'(ch));
    endtask

    // Called #1 after the commit edge; walks the fixed-length expected stream.
    task automatic expect_stream(input string tag, input logic [7:0] exp[$], input bit toggle);
        check({tag, ".busy"}, 32'(o_busy), 32'd1);
        for (int k = 0; k < exp.size(); k++) begin
            check($sformatf("%s.valid[%0d]", tag, k), 32'(o_tx_valid), 32'd1);
            check($sformatf("%s.data[%0d]", tag, k),  32'(o_tx_data),  32'(exp[k]));
            if (toggle) begin
                i_tx_ready = 1'b0;
                @(posedge clk);
                #1;
                check($sformatf("%s.hold[%0d]", tag, k),  32'(o_tx_data),  32'(exp[k]));
                check($sformatf("%s.holdv[%0d]", tag, k), 32'(o_tx_valid), 32'd1);
            end
            i_tx_ready = 1'b1;
            @(posedge clk);
            #1;
        end
        check({tag, ".end_valid"}, 32'(o_tx_valid), 32'd0);
        check({tag, ".end_busy"},  32'(o_busy),     32'd0);
        check_edit({tag, ".end"}, 0, 0, 8'h00);
    endtask

    initial begin
        logic [7:0] q[$];

        i_sclr = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        i_sclr = 1'b0;
        check("rst.valid", 32'(o_tx_valid), 32'd0);
        check("rst.data",  32'(o_tx_data),  32'd0);
        check("rst.busy",  32'(o_busy),     32'd0);
        check("rst.full",  32'(o_full),     32'd0);
        check_edit("rst", 0, 0, 8'h00);

        // ABC then commit
        do_ev(EV_ASCII, 8'h41); check_edit("abc1", 1, 1, 8'h41);
        do_ev(EV_ASCII, 8'h42); check_edit("abc2", 2, 2, 8'h42);
        do_ev(EV_ASCII, 8'h43); check_edit("abc3", 3, 3, 8'h43);
        do_ev(EV_DOWN, 8'h00);
        q = '{8'h41, 8'h42, 8'h43, 8'h00};
        expect_stream("abc", q, 1'b0);

        // A C left B
        do_ev(EV_ASCII, 8'h41);
        do_ev(EV_ASCII, 8'h43);
        do_ev(EV_LEFT, 8'h00); check_edit("acl", 2, 1, 8'h41);
        do_ev(EV_ASCII, 8'h42);
`ifdef STR_BUILDER_INSERT_EN
        check_edit("acb", 3, 2, 8'h42);
        q = '{8'h41, 8'h42, 8'h43, 8'h00};
`else
        check_edit("acb", 2, 2, 8'h42);
        q = '{8'h41, 8'h42, 8'h00};
`endif
        do_ev(EV_DOWN, 8'h00);
        expect_stream("acb", q, 1'b0);

        // Backspace and cursor limits
        do_ev(EV_ASCII, 8'h41);
        do_ev(EV_ASCII, 8'h42);
        do_ev(EV_LEFT, 8'h00);
        do_ev(EV_BS, 8'h00);    check_edit("bs1", 1, 0, 8'h00);
        do_ev(EV_BS, 8'h00);    check_edit("bs0", 1, 0, 8'h00);
        do_ev(EV_LEFT, 8'h00);  check_edit("left0", 1, 0, 8'h00);
        do_ev(EV_RIGHT, 8'h00); check_edit("right1", 1, 1, 8'h42);
        do_ev(EV_RIGHT, 8'h00); check_edit("rightmax", 1, 1, 8'h42);
        do_ev(EV_DOWN, 8'h00);
        q = '{8'h42, 8'h00};
        expect_stream("bs", q, 1'b0);

        // Fill to DEPTH, overflow attempt, throttled stream
        q = {};
        for (int i = 0; i < 16; i++) begin
            do_ev(EV_ASCII, 8'(8'h61 + i));
            q.push_back(8'(8'h61 + i));
        end
        q.push_back(8'h00);
        check("fill.full", 32'(o_full), 32'd1);
        check_edit("fill", 16, 16, 8'h70);
        do_ev(EV_ASCII, 8'h7A);
        check("ovf.full", 32'(o_full), 32'd1);
        check_edit("ovf", 16, 16, 8'h70);
        do_ev(EV_DOWN, 8'h00);
        expect_stream("full", q, 1'b1);
        check("full.clr", 32'(o_full), 32'd0);

        // ascii wins over down; ascii during SEND is ignored
        do_ev(EV_ASCII | EV_DOWN, 8'h58);
        check("prio.busy", 32'(o_busy), 32'd0);
        check_edit("prio", 1, 1, 8'h58);
        do_ev(EV_DOWN, 8'h00);
        check("snd.data0", 32'(o_tx_data), 32'h58);
        i_tx_ready = 1'b0;
        i_ascii    = 8'h5A;
        i_ascii_en = 1'b1;
        @(posedge clk);
        #1;
        i_ascii_en = 1'b0;
        check("snd.hold", 32'(o_tx_data), 32'h58);
        check_edit("snd.noedit", 1, 1, 8'h58);
        i_tx_ready = 1'b1;
        @(posedge clk);
        #1;
        check("snd.term",  32'(o_tx_data),  32'h00);
        check("snd.tvld",  32'(o_tx_valid), 32'd1);
        @(posedge clk);
        #1;
        check("snd.done", 32'(o_tx_valid), 32'd0);
        check_edit("snd.end", 0, 0, 8'h00);

        // Reset in the middle of a stream
        for (int i = 0; i < 5; i++) do_ev(EV_ASCII, 8'(8'h31 + i));
        do_ev(EV_DOWN, 8'h00);
        check("abort.d0", 32'(o_tx_data), 32'h31);
        @(posedge clk);
        #1;
        check("abort.d1", 32'(o_tx_data), 32'h32);
        @(posedge clk);
        #1;
        check("abort.d2", 32'(o_tx_data), 32'h33);
        i_sclr = 1'b1;
        @(posedge clk);
        #1;
        i_sclr = 1'b0;
        check("abort.valid", 32'(o_tx_valid), 32'd0);
        check("abort.busy",  32'(o_busy),     32'd0);
        check("abort.data",  32'(o_tx_data),  32'd0);
        check_edit("abort", 0, 0, 8'h00);

        // Commit with empty buffer
        do_ev(EV_DOWN, 8'h00);
        q = '{8'h00};
        expect_stream("empty", q, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/str_builder.md
# str_builder

Line-editing string buffer that consumes the per-key event strobes produced by the keypad front end (`key_in`): a printable character, cursor right, cursor left, backspace, and commit on the down key. It holds up to DEPTH characters with an edit cursor. On commit it streams the string out over a valid/ready byte interface, appends a 0x00 terminator, then clears itself. A cursor-side character and the length are exported for the 7-segment/LED status display.

## Interface

**Parameters**
- AW, default 4: address width; DEPTH = 2**AW characters.

**Ports**
- clk, input, 1: clock.
- i_sclr, input, 1: synchronous, active-high reset.
- i_ascii, input, 8: character code, sampled when i_ascii_en = 1.
- i_ascii_en, input, 1: one-cycle strobe requesting a character insert.
- i_right_en, input, 1: one-cycle strobe, cursor right.
- i_left_en, input, 1: one-cycle strobe, cursor left.
- i_bs_en, input, 1: one-cycle strobe, backspace.
- i_down_en, input, 1: one-cycle strobe, commit.
- o_tx_data, output, 8: streamed byte.
- o_tx_valid, output, 1: o_tx_data is valid.
- i_tx_ready, input, 1: sink accepts the byte; transfer occurs when o_tx_valid & i_tx_ready.
- o_busy, output, 1: block is in SEND state.
- o_full, output, 1: length equals DEPTH.
- o_len, output, AW+1: current string length.
- o_cursor, output, AW+1: cursor position, 0..len.
- o_cur_char, output, 8: buf[cursor-1]; 0x00 when cursor = 0.

## Operation

- Storage: DEPTH x 8-bit register array buf, length len, cursor cur. Invariant: 0 ≤ cur ≤ len ≤ DEPTH.
- FSM has two states:
  - EDIT (reset state).
  - SEND, with send index idx of width AW+1.
- EDIT. At most one event acts per cycle. Priority: ascii > bs > right > left > down. Lower-priority strobes in the same cycle are dropped, not queued.
  - ascii: see Configuration. Ignored when no room is available. Otherwise cur increments by 1.
  - bs: if cur > 0, remove buf[cur-1], shift buf[cur..len-1] down by 1, then decrement len and cur. Ignored when cur = 0.
  - right: cur increments by 1 if cur < len; otherwise ignored.
  - left: cur decrements by 1 if cur > 0; otherwise ignored.
  - down: idx = 0, go to SEND. Allowed when len = 0; in that case only the terminator is sent.
- SEND.
  - o_tx_valid = 1.
  - o_tx_data = buf[idx] while idx < len; 0x00 when idx = len.
  - On each transfer, idx increments by 1.
  - The transfer of the terminator sets len = 0, cur = 0, and returns to EDIT.
  - All edit strobes are ignored, including down.
  - buf contents are not required to be zeroed on clear.
- o_busy = (state == SEND). o_full = (len == DEPTH). o_cur_char is combinational from cur and buf.
- i_sclr: every state returns to reset values in the same edge, including mid-SEND; the stream aborts without a terminator.
- Reset values: state = EDIT, len = 0, cur = 0, idx = 0, o_tx_valid = 0, o_tx_data = 0x00, o_busy = 0, o_full = 0, o_cur_char = 0x00.

## Timing

- Each edit strobe at edge N is visible on o_len / o_cursor / o_cur_char after edge N.
- Commit: strobe at edge N; o_tx_valid = 1 and o_busy = 1 after edge N.
- o_tx_data and o_tx_valid are registered. They stay stable while i_tx_ready = 0.
- With i_tx_ready held at 1, one byte transfers per cycle. A string of length L takes L+1 transfer cycles.
- After the terminator transfers at edge M: o_tx_valid = 0 and o_busy = 0 after edge M. An edit strobe is accepted at edge M+1.
- i_tx_ready is ignored in EDIT. The sink may hold it high constantly.

## Configuration

- Macro `STR_BUILDER_INSERT_EN`.
- Defined: insert mode.
  - ascii shifts buf[cur..len-1] up by 1 and writes buf[cur] = i_ascii; len increments by 1.
  - Requires len < DEPTH; ignored when o_full.
- Undefined: overwrite mode.
  - If cur < len: buf[cur] = i_ascii, len unchanged.
  - If cur = len < DEPTH: append, len increments by 1.
  - Ignored when cur = DEPTH.
- bs, cursor, and SEND behaviour are identical in both modes.

## Test plan

- Type 'A','B','C' (0x41,0x42,0x43), then down with i_tx_ready = 1 → stream 0x41,0x42,0x43,0x00 on consecutive cycles; then len = 0, cur = 0, o_busy = 0.
- Type 'A','C', left, type 'B', down → insert build: stream 41,42,43,00. Overwrite build: stream 41,42,00.
- Type 'A','B', left, bs → len = 1, cur = 0, o_cur_char = 0x00. Also: bs or left at cur = 0 → no change. Right at cur = len → no change.
- Fill to DEPTH = 16 characters → o_full = 1; a 17th ascii strobe → len stays 16. Down with i_tx_ready toggling 1/0 → 16 bytes plus terminator, each held stable while ready = 0.
- Assert ascii and down in the same cycle → only the insert occurs. Strobe ascii during SEND → ignored; streamed data is unchanged.
- Assert i_sclr mid-SEND after 2 of 5 bytes → next cycle o_tx_valid = 0, len = 0, cur = 0, state EDIT. Commit on an empty buffer → single byte 0x00.
